// File: rtl/osd_rst_seq.sv
// Reset sequencer: stretches system/CPU reset requests and releases system first, CPU later.
// Optional 2-flop input synchronizers on both requests when OSD_RST_SEQ_INSYNC_EN is defined.
module osd_rst_seq #(
  parameter int SYS_HOLD_CYCLES = 16,
  parameter int CPU_HOLD_CYCLES = 8,
  parameter int CNT_WIDTH = $clog2(((SYS_HOLD_CYCLES > CPU_HOLD_CYCLES) ?
                                    SYS_HOLD_CYCLES : CPU_HOLD_CYCLES) + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic sys_rst_req,
  input  logic cpu_rst_req,
  output logic sys_rst_o,
  output logic cpu_rst_o,
  output logic rst_busy
);

  typedef enum logic [1:0] {
    SYS_HOLD = 2'd0,
    CPU_HOLD = 2'd1,
    RUN      = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] SYS_TERM = CNT_WIDTH'(SYS_HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CPU_TERM = CNT_WIDTH'(CPU_HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t                 state, state_next;
  logic [CNT_WIDTH-1:0]   cnt, cnt_next;
  logic                   sys_req, cpu_req;
  logic                   sys_next, cpu_next, busy_next;

`ifdef OSD_RST_SEQ_INSYNC_EN
  logic [1:0] sys_sync, cpu_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sys_sync <= '0;
      cpu_sync <= '0;
    end else begin
      sys_sync <= {sys_sync[0], sys_rst_req};
      cpu_sync <= {cpu_sync[0], cpu_rst_req};
    end
  end

  assign sys_req = sys_sync[1];
  assign cpu_req = cpu_sync[1];
`else
  assign sys_req = sys_rst_req;
  assign cpu_req = cpu_rst_req;
`endif

  // Outputs are flopped from the next-state decode, so the reset nets come
  // straight off flip-flops and release cleanly on a clock edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SYS_HOLD;
      cnt       <= '0;
      sys_rst_o <= 1'b1;
      cpu_rst_o <= 1'b1;
      rst_busy  <= 1'b1;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      sys_rst_o <= sys_next;
      cpu_rst_o <= cpu_next;
      rst_busy  <= busy_next;
    end
  end

  // NOTE: defaults first so every path assigns every signal and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      SYS_HOLD: begin
        if (sys_req) begin
          cnt_next = '0;
        end else if (cnt == SYS_TERM) begin
          state_next = CPU_HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      CPU_HOLD: begin
        if (sys_req) begin
          state_next = SYS_HOLD;
          cnt_next   = '0;
        end else if (cpu_req) begin
          cnt_next = '0;
        end else if (cnt == CPU_TERM) begin
          state_next = RUN;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      RUN: begin
        if (sys_req) begin
          state_next = SYS_HOLD;
          cnt_next   = '0;
        end else if (cpu_req) begin
          state_next = CPU_HOLD;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = SYS_HOLD;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    sys_next  = 1'b1;
    cpu_next  = 1'b1;
    busy_next = 1'b1;
    unique case (state_next)
      SYS_HOLD: begin
        sys_next = 1'b1;
        cpu_next = 1'b1;
      end
      CPU_HOLD: begin
        sys_next = 1'b0;
        cpu_next = 1'b1;
      end
      RUN: begin
        sys_next  = 1'b0;
        cpu_next  = 1'b0;
        busy_next = 1'b0;
      end
      default: begin
        sys_next = 1'b1;
        cpu_next = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_osd_rst_seq.sv
// Directed bench for osd_rst_seq: expected {sys,cpu,busy} per edge queued up front,
// popped and compared 1 ns after each rising edge.
module tb_osd_rst_seq;

`ifdef OSD_RST_SEQ_INSYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic clk = 1'b0;
  logic clk_en = 1'b1;
  logic rst;
  logic sys_rst_req;
  logic cpu_rst_req;
  logic sys_rst_o;
  logic cpu_rst_o;
  logic rst_busy;

  int tests = 0;
  int fails = 0;

  logic [2:0] exp_q[$];

  osd_rst_seq #(
    .SYS_HOLD_CYCLES(16),
    .CPU_HOLD_CYCLES(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sys_rst_req(sys_rst_req),
    .cpu_rst_req(cpu_rst_req),
    .sys_rst_o  (sys_rst_o),
    .cpu_rst_o  (cpu_rst_o),
    .rst_busy   (rst_busy)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic push(input int n, input logic s, input logic c, input logic b);
    for (int i = 0; i < n; i++) exp_q.push_back({s, c, b});
  endtask

  task automatic check_out(input string tag);
    logic [2:0] exp_v;
    logic [2:0] obs_v;
    obs_v = {sys_rst_o, cpu_rst_o, rst_busy};
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: observed %b but scoreboard empty", tag, obs_v);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs_v === exp_v) else begin
        fails++;
        $error("FAIL %s: observed sys/cpu/busy=%b expected %b at %0t", tag, obs_v, exp_v, $time);
      end
    end
  endtask

  task automatic step(input string tag, input logic sr, input logic cr);
    sys_rst_req = sr;
    cpu_rst_req = cr;
    @(posedge clk);
    #1;
    check_out(tag);
    sys_rst_req = 1'b0;
    cpu_rst_req = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) step(tag, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    sys_rst_req = 1'b0;
    cpu_rst_req = 1'b0;

    // Reset state before any edge
    #1;
    push(1, 1, 1, 1);
    check_out("reset_no_edge");

    // rst held for 3 edges
    push(3, 1, 1, 1);
    for (int i = 0; i < 3; i++) step("reset_hold", 0, 0);

    // Power-on release: sys falls after edge 16, cpu/busy after edge 24
    @(negedge clk);
    rst = 1'b0;
    push(15, 1, 1, 1);
    push(8, 0, 1, 1);
    push(4, 0, 0, 0);
    drain("power_on");

    // 1-cycle CPU pulse in RUN
    push(SYNC_LAT, 0, 0, 0);
    push(8, 0, 1, 1);
    push(2, 0, 0, 0);
    step("cpu_pulse", 0, 1);
    drain("cpu_pulse");

    // Second CPU request during CPU_HOLD restarts the CPU hold
    push(SYNC_LAT, 0, 0, 0);
    push(11, 0, 1, 1);
    push(2, 0, 0, 0);
    step("cpu_rehold", 0, 1);
    step("cpu_rehold", 0, 0);
    step("cpu_rehold", 0, 0);
    step("cpu_rehold", 0, 1);
    drain("cpu_rehold");

    // System request held 5 edges in RUN
    push(SYNC_LAT, 0, 0, 0);
    push(20, 1, 1, 1);
    push(8, 0, 1, 1);
    push(2, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("sys_5cyc", 1, 0);
    drain("sys_5cyc");

    // System pulse while CPU_HOLD has cnt=5 restarts full 16+8 sequence
    push(SYNC_LAT, 0, 0, 0);
    push(6, 0, 1, 1);
    push(16, 1, 1, 1);
    push(8, 0, 1, 1);
    push(2, 0, 0, 0);
    step("sys_in_cpuhold", 0, 1);
    for (int i = 0; i < 5; i++) step("sys_in_cpuhold", 0, 0);
    step("sys_in_cpuhold", 1, 0);
    drain("sys_in_cpuhold");

    // Both requests together in RUN: system wins
    push(SYNC_LAT, 0, 0, 0);
    push(16, 1, 1, 1);
    push(8, 0, 1, 1);
    push(2, 0, 0, 0);
    step("both_req", 1, 1);
    drain("both_req");

    // rst asserted mid-CPU_HOLD with clock stopped
    push(SYNC_LAT, 0, 0, 0);
    push(4 - SYNC_LAT, 0, 1, 1);
    step("pre_async", 0, 1);
    for (int i = 0; i < 3; i++) step("pre_async", 0, 0);
    @(negedge clk);
    clk_en = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    push(1, 1, 1, 1);
    check_out("async_rst");
    #20;
    push(1, 1, 1, 1);
    check_out("async_rst_hold");
    clk_en = 1'b1;

    // Restart from SYS_HOLD after rst falls
    push(2, 1, 1, 1);
    step("restart_hold", 0, 0);
    step("restart_hold", 0, 0);
    @(negedge clk);
    rst = 1'b0;
    push(15, 1, 1, 1);
    push(8, 0, 1, 1);
    push(2, 0, 0, 0);
    drain("restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the bench always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed hang expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/osd_rst_seq.md
# osd_rst_seq

Reset sequencer that sits directly downstream of the subnet control module. It consumes that module's system and CPU reset requests and drives the actual system and CPU reset nets. It stretches each request to a guaranteed minimum width and releases the resets in a fixed order: system first, CPU a programmable number of cycles later. Deassertion is always synchronous to `clk`, so the reset trees downstream never see a release glitch.

## Interface
Parameters:
- `SYS_HOLD_CYCLES`, default 16: minimum cycles `sys_rst_o` stays high after the last sampled system request; must be ≥ 1.
- `CPU_HOLD_CYCLES`, default 8: cycles `cpu_rst_o` stays high after `sys_rst_o` releases, or after the last sampled CPU request; must be ≥ 1.
- `CNT_WIDTH`, default `$clog2(max(SYS_HOLD_CYCLES, CPU_HOLD_CYCLES)+1)`: hold counter width; derived, not overridden.

Ports (one clock; reset is asynchronous and active-high):
- `clk`, input, 1: sole clock.
- `rst`, input, 1: asynchronous, active-high reset; assertion forces both outputs high with no clock edge required.
- `sys_rst_req`, input, 1: system reset request, level, synchronous to `clk` (driven by the subnet control module's `sys_rst`).
- `cpu_rst_req`, input, 1: CPU reset request, level, synchronous to `clk` (driven by the subnet control module's `cpu_rst`).
- `sys_rst_o`, output, 1: registered system reset.
- `cpu_rst_o`, output, 1: registered CPU reset.
- `rst_busy`, output, 1: high whenever the FSM is not in RUN.

## Operation
- FSM states: SYS_HOLD, CPU_HOLD, RUN. One hold counter `cnt` of width `CNT_WIDTH`.
- Outputs are registered and decoded from the state:
  - SYS_HOLD: `sys_rst_o` = 1, `cpu_rst_o` = 1.
  - CPU_HOLD: `sys_rst_o` = 0, `cpu_rst_o` = 1.
  - RUN: `sys_rst_o` = 0, `cpu_rst_o` = 0.
  - `rst_busy` = (state != RUN).
- While `rst` is high: state = SYS_HOLD, `cnt` = 0, `sys_rst_o` = 1, `cpu_rst_o` = 1, `rst_busy` = 1.
- SYS_HOLD, evaluated per edge in this priority:
  - `sys_rst_req` high: `cnt` ← 0.
  - else if `cnt` == `SYS_HOLD_CYCLES`-1: go to CPU_HOLD, `cnt` ← 0.
  - else: `cnt` ← `cnt`+1.
  - `cpu_rst_req` is ignored in this state (CPU is already held).
- CPU_HOLD, evaluated per edge in this priority:
  - `sys_rst_req` high: go to SYS_HOLD, `cnt` ← 0.
  - else if `cpu_rst_req` high: `cnt` ← 0.
  - else if `cnt` == `CPU_HOLD_CYCLES`-1: go to RUN.
  - else: `cnt` ← `cnt`+1.
- RUN, evaluated per edge in this priority:
  - `sys_rst_req` high: go to SYS_HOLD, `cnt` ← 0.
  - else if `cpu_rst_req` high: go to CPU_HOLD, `cnt` ← 0.
- Simultaneous `sys_rst_req` and `cpu_rst_req`: the system request always wins.
- The counter never wraps; it is bounded by the terminal compare.

## Timing
- Request-to-assert latency: 1 edge. A request sampled high at edge N makes the output high after edge N.
- System release: `sys_rst_o` falls after edge L+`SYS_HOLD_CYCLES`, where L is the last edge that sampled `sys_rst_req` high. After `rst` deassertion, L is the last edge with `rst` high (no edge), so the fall is after the `SYS_HOLD_CYCLES`-th edge.
- CPU release: `cpu_rst_o` falls `CPU_HOLD_CYCLES` edges after `sys_rst_o` falls, or `CPU_HOLD_CYCLES` edges after the last edge sampling `cpu_rst_req` high.
- A 1-cycle request pulse always yields the full minimum hold width.
- `rst` asserted mid-sequence: both outputs go high asynchronously and the sequence restarts from SYS_HOLD once `rst` falls.

## Configuration
- Macro: `OSD_RST_SEQ_INSYNC_EN`.
- Defined: each request input passes through a 2-flop synchronizer, async-reset to 0, before the FSM. Request-to-assert latency becomes 3 edges and release timing shifts by 2 edges. This allows request sources outside the `clk` domain.
- Undefined: requests feed the FSM directly, with the latencies given in Timing. Ports are identical either way.

## Test plan
Defaults `SYS_HOLD_CYCLES`=16, `CPU_HOLD_CYCLES`=8, macro undefined unless stated.
- Power-on: `rst` high 3 cycles, then low, requests 0 → `sys_rst_o` falls after edge 16, `cpu_rst_o` and `rst_busy` fall after edge 24.
- In RUN, `cpu_rst_req` 1-cycle pulse at edge N → `cpu_rst_o` high after edge N, low after edge N+8; `sys_rst_o` stays 0 throughout.
- In RUN, `sys_rst_req` high for edges N..N+4 → both outputs high after edge N; `sys_rst_o` low after edge N+20; `cpu_rst_o` low after edge N+28.
- In CPU_HOLD (cnt=5), `sys_rst_req` pulse → `sys_rst_o` re-asserts after that edge and the full 16+8 sequence restarts. Separately, `sys_rst_req` and `cpu_rst_req` both high in RUN → SYS_HOLD entered (system priority).
- `rst` asserted mid-CPU_HOLD with `clk` stopped → `sys_rst_o` and `cpu_rst_o` high immediately with no edge.
- With `OSD_RST_SEQ_INSYNC_EN` defined, `cpu_rst_req` 1-cycle pulse at edge N in RUN → `cpu_rst_o` high after edge N+2, low after edge N+10.
